// File: rtl/alu_op_queue.sv
// alu_op_queue: DEPTH-entry FIFO of {command, a, b} ALU operations.
// Head entry is presented combinationally from storage; there is no bypass
// from the input side, so a pushed op becomes visible one edge later.
module alu_op_queue #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_command,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            flush,
  output logic            alu_valid,
  input  logic            alu_accept,
  output logic [2:0]      alu_command,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [CNTW-1:0] count,
  output logic [15:0]     issued
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t             mem [DEPTH];
  logic [PTRW-1:0] head, tail;
  logic            push, pop;
  op_t             head_op;

  // Handshakes; flush suppresses both sides, a full queue refuses a push
  // even when the head is popped in the same cycle.
  always_comb begin
    in_ready  = !reset && (count != CNTW'(DEPTH)) && !flush;
    alu_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = alu_valid && alu_accept && !flush;
  end

  // Head entry straight from storage, forced to zero while empty.
  always_comb begin
    head_op     = alu_valid ? mem[head] : '0;
    alu_command = head_op.cmd;
    alu_a       = head_op.a;
    alu_b       = head_op.b;
  end

  // Storage write at the tail; contents are never cleared.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{cmd: in_command, a: in_a, b: in_b};
  end

  // Pointers, occupancy and issue counter. DEPTH is a power of two, so the
  // pointers wrap naturally; occupancy comes from the count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      issued <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTRW'(1);
      if (pop) begin
        head   <= head + PTRW'(1);
        issued <= issued + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_queue.sv
// Directed-vector bench for alu_op_queue (DEPTH=4).
module tb_alu_op_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, alu_valid, alu_accept;
  logic [2:0]  in_command, alu_command;
  logic [31:0] in_a, in_b, alu_a, alu_b;
  logic [2:0]  count;
  logic [15:0] issued;

  int nvec = 0;
  int nerr = 0;

  alu_op_queue #(.DEPTH(4), .CNTW(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_command(in_command), .in_a(in_a), .in_b(in_b), .flush(flush),
    .alu_valid(alu_valid), .alu_accept(alu_accept), .alu_command(alu_command),
    .alu_a(alu_a), .alu_b(alu_b), .count(count), .issued(issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld;
    logic [2:0]  cmd;
    logic [31:0] a, b;
    logic        fl, acc;
    logic        e_rdy, e_vld;
    logic [2:0]  e_cmd;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_cnt;
    logic [15:0] e_iss;
  } vec_t;

  vec_t vt[$];
  logic [66:0] model[$];
  logic [15:0] m_iss;

  function automatic vec_t mk(logic rst, logic vld, logic [2:0] cmd, logic [31:0] a,
                              logic [31:0] b, logic fl, logic acc, logic e_rdy,
                              logic e_vld, logic [2:0] e_cmd, logic [31:0] e_a,
                              logic [31:0] e_b, logic [2:0] e_cnt, logic [15:0] e_iss);
    vec_t v;
    v.rst = rst; v.vld = vld; v.cmd = cmd; v.a = a; v.b = b; v.fl = fl; v.acc = acc;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_cmd = e_cmd; v.e_a = e_a; v.e_b = e_b;
    v.e_cnt = e_cnt; v.e_iss = e_iss;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic vld,
                         input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] cnt, input logic [15:0] iss);
    chk({tag, ".in_ready"},    32'(in_ready),    32'(rdy));
    chk({tag, ".alu_valid"},   32'(alu_valid),   32'(vld));
    chk({tag, ".alu_command"}, 32'(alu_command), 32'(cmd));
    chk({tag, ".alu_a"},       alu_a,            a);
    chk({tag, ".alu_b"},       alu_b,            b);
    chk({tag, ".count"},       32'(count),       32'(cnt));
    chk({tag, ".issued"},      32'(issued),      32'(iss));
  endtask

  // One clock of a model-checked sequence (no flush, no reset).
  task automatic step(input logic vld, input logic [2:0] cmd, input logic [31:0] a,
                      input logic [31:0] b, input logic acc, input string tag);
    logic do_push, do_pop;
    logic [66:0] h;
    reset = 0; flush = 0; in_valid = vld; in_command = cmd; in_a = a; in_b = b;
    alu_accept = acc;
    do_push = vld && (model.size() < 4);
    do_pop  = acc && (model.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(model.pop_front());
      m_iss = m_iss + 16'd1;
    end
    if (do_push) model.push_back({cmd, a, b});
    h = (model.size() > 0) ? model[0] : 67'd0;
    chk_all(tag, model.size() < 4, model.size() > 0, h[66:64], h[63:32], h[31:0],
            3'(model.size()), m_iss);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_command = 0; in_a = 0; in_b = 0; flush = 0; alu_accept = 0;

    // rst vld cmd a b fl acc | rdy vld cmd a b cnt issued
    vt.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,1,7,3,0,0, 1,1,1,7,3,1,0));
    vt.push_back(mk(0,0,0,0,0,0,1, 1,0,0,0,0,0,1));
    vt.push_back(mk(0,1,0,10,20,0,0, 1,1,0,10,20,1,1));
    vt.push_back(mk(0,1,2,11,21,0,0, 1,1,0,10,20,2,1));
    vt.push_back(mk(0,1,3,12,22,0,0, 1,1,0,10,20,3,1));
    vt.push_back(mk(0,1,4,13,23,0,0, 0,1,0,10,20,4,1));
    vt.push_back(mk(0,1,5,14,24,0,0, 0,1,0,10,20,4,1));
    vt.push_back(mk(0,1,5,14,24,0,1, 1,1,2,11,21,3,2));
    vt.push_back(mk(0,1,5,14,24,0,0, 0,1,2,11,21,4,2));
    vt.push_back(mk(0,0,0,0,0,0,1, 1,1,3,12,22,3,3));
    vt.push_back(mk(0,0,0,0,0,0,1, 1,1,4,13,23,2,4));
    vt.push_back(mk(0,0,0,0,0,0,1, 1,1,5,14,24,1,5));
    vt.push_back(mk(0,0,0,0,0,0,1, 1,0,0,0,0,0,6));
    vt.push_back(mk(0,1,7,1,2,0,0, 1,1,7,1,2,1,6));
    vt.push_back(mk(0,1,6,3,4,0,0, 1,1,7,1,2,2,6));
    vt.push_back(mk(0,1,5,5,6,0,0, 1,1,7,1,2,3,6));
    vt.push_back(mk(0,1,1,9,9,1,1, 0,0,0,0,0,0,6));
    vt.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,6));
    for (int i = 0; i < 5; i++) vt.push_back(mk(0,0,0,0,0,0,1, 1,0,0,0,0,0,6));
    vt.push_back(mk(0,1,4,32'hFFFF_FFFF,32'h8000_0000,0,0, 1,1,4,32'hFFFF_FFFF,32'h8000_0000,1,6));
    vt.push_back(mk(0,1,3,5,6,0,1, 1,1,3,5,6,1,7));

    foreach (vt[i]) begin
      reset = vt[i].rst; in_valid = vt[i].vld; in_command = vt[i].cmd;
      in_a = vt[i].a; in_b = vt[i].b; flush = vt[i].fl; alu_accept = vt[i].acc;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_vld, vt[i].e_cmd,
              vt[i].e_a, vt[i].e_b, vt[i].e_cnt, vt[i].e_iss);
    end

    // Steady push+pop at count=2 across pointer wrap.
    model.delete();
    model.push_back({3'd3, 32'd5, 32'd6});
    m_iss = 16'd7;
    step(1, 3'd2, 32'd100, 32'd200, 0, "fill2");
    for (int i = 0; i < 10; i++)
      step(1, 3'(i), 32'd1000 + 32'(i), 32'd2000 + 32'(i), 1, $sformatf("pp%0d", i));
    step(1, 3'd6, 32'd77, 32'd88, 0, "fill3");

    // Asynchronous reset between edges with three entries queued.
    in_valid = 0; alu_accept = 0;
    #2 reset = 1;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 0;
    #1 chk("rdy_after_rst", 32'(in_ready), 32'd1);
    in_valid = 1; in_command = 3'd1; in_a = 32'd7; in_b = 32'd3;
    @(posedge clk);
    #1 chk_all("post_rst_push", 1, 1, 1, 7, 3, 1, 0);
    in_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_queue.md
ALU_OP_QUEUE -- requirements
Module: alu_op_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter CNTW, default 3, width of occupancy count; equals log2(DEPTH)+1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 in_valid  input  1  producer offers an operation this cycle.
REQ-006 in_ready  output  1  queue accepts an operation this cycle.
REQ-007 in_command  input  3  ALU command: 000 add, 001 sub, 010 xor, 011 slt, 100 and, 101 nand, 110 nor, 111 or.
REQ-008 in_a  input  32  operand A.
REQ-009 in_b  input  32  operand B.
REQ-010 flush  input  1  synchronous discard of all queued entries.
REQ-011 alu_valid  output  1  head entry present on alu_command/alu_a/alu_b.
REQ-012 alu_accept  input  1  consumer takes the head entry this cycle.
REQ-013 alu_command  output  3  head command, to the ALU command input.
REQ-014 alu_a  output  32  head operand A, to the ALU a input.
REQ-015 alu_b  output  32  head operand B, to the ALU b input.
REQ-016 count  output  CNTW  current occupancy, 0..DEPTH.
REQ-017 issued  output  16  number of entries popped since reset; wraps at 65535 -> 0.

Function
REQ-018 Push occurs when in_valid && in_ready; entry {in_command, in_a, in_b} written at the tail, tail pointer advances mod DEPTH.
REQ-019 Pop occurs when alu_valid && alu_accept; head pointer advances mod DEPTH; issued increments by 1.
REQ-020 in_ready = (count != DEPTH) && !flush; depends only on registered state and flush, never on in_valid or alu_accept.
REQ-021 alu_valid = (count != 0); alu_command/alu_a/alu_b read the head entry directly from storage.
REQ-022 When count == 0, alu_command = 3'b000, alu_a = 0, alu_b = 0.
REQ-023 Latency: an entry pushed at edge N is visible with alu_valid=1 after edge N if the queue was empty; no same-cycle bypass from in_* to alu_*.
REQ-024 Order is strict FIFO; entries never reorder, duplicate or drop except by flush or reset.
REQ-025 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-026 Full (count == DEPTH): in_ready = 0 even if alu_accept = 1 that cycle; pop proceeds, push resumes next cycle.
REQ-027 Empty: alu_accept ignored; no pointer movement, issued unchanged.
REQ-028 Outputs alu_* hold stable while alu_valid=1 and alu_accept=0.
REQ-029 flush=1 at an edge: count, head and tail pointers set to 0; any push or pop that cycle is suppressed; issued unchanged.
REQ-030 Storage contents need not be cleared by reset or flush; only pointers and count.
REQ-031 Pointer wrap: after DEPTH pushes tail returns to 0; occupancy computed from count register, not pointer difference.

Reset
REQ-032 While reset=1: count=0, head=tail=0, issued=0, alu_valid=0, in_ready=0, alu_* = 0.
REQ-033 in_ready rises in the first cycle after reset deasserts; reset asserted mid-operation discards all entries without waiting for clk.

Verification
REQ-034 Reset then push {001, 7, 3} -> next cycle alu_valid=1, alu_command=001, alu_a=7, alu_b=3, count=1.
REQ-035 Push 4 ops with alu_accept=0 -> count=4, in_ready=0; fifth in_valid held until one pop; pops return ops in push order; issued=4 after draining.
REQ-036 count=2, push and pop same cycle for 10 cycles -> count stays 2, order preserved across pointer wrap.
REQ-037 count=3, flush=1 with in_valid=1 and alu_accept=1 -> next cycle count=0, alu_valid=0, issued unchanged, pushed op discarded.
REQ-038 Empty queue, alu_accept=1 for 5 cycles -> issued stays 0, alu_command=000, alu_a=alu_b=0.
REQ-039 Assert reset asynchronously between edges with count=3 -> count=0, alu_valid=0 before next clk edge; issued=0.
